comms_tx_scheduler: RTL and testbench

//  Queues GPP transmit requests (destination node, word count) and sequences them one at a time

---
 rtl/comms_tx_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_comms_tx_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comms_tx_scheduler.sv
// Transmit request scheduler: FIFO of (dest,len) run through ping/ack/complete with bounded retry and linear backoff.
// Push to tx_start takes 3 edges; req_ready = !full. Optional COMMS_SCHED_STATS_EN adds sent/fail counters.
module comms_tx_scheduler #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 3,
  parameter int BACKOFF_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] node_id,
  input  logic [15:0] max_node,
  input  logic        req_valid,
  input  logic [15:0] req_dest,
  input  logic [15:0] req_len,
  output logic        req_ready,
  output logic        tx_start,
  output logic [15:0] tx_dest,
  output logic [15:0] tx_len,
  input  logic        tx_ack,
  input  logic        tx_nack,
  input  logic        tx_complete,
  output logic        sched_busy,
  output logic        done_pulse,
  output logic        err_pulse,
  output logic [1:0]  err_code
`ifdef COMMS_SCHED_STATS_EN
  ,
  output logic [15:0] sent_count,
  output logic [15:0] fail_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [15:0]   TIMER_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  typedef struct packed {
    logic [15:0] dest;
    logic [15:0] len;
  } req_t;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_ACK, BACKOFF, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  req_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty, fifo_full, push, pop;
  logic [15:0]   timer, bo_cnt, bo_last;
  logic [RW-1:0] retry_cnt;
  logic          bad_req, timer_exp, ack_fail, retry_ok;
  logic [1:0]    err_code_nxt;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign push       = req_valid && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign req_ready  = !fifo_full;
  assign sched_busy = (state != IDLE) || !fifo_empty;

  assign bad_req   = (tx_dest == node_id) || (tx_dest >= max_node) || (tx_len == 16'd0);
  assign timer_exp = (timer == TIMER_LAST);
  // NACK takes priority over a same-cycle ACK
  assign ack_fail  = tx_nack || timer_exp;
  assign retry_ok  = (retry_cnt < RETRY_MAX);
  assign bo_last   = 16'(BACKOFF_CYC * int'(retry_cnt)) - 16'd1;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{dest: req_dest, len: req_len};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!fifo_empty) state_nxt = CHECK;
      CHECK:     state_nxt = bad_req ? IDLE : ISSUE;
      ISSUE:     state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_fail)    state_nxt = retry_ok ? BACKOFF : IDLE;
        else if (tx_ack) state_nxt = WAIT_DONE;
      end
      BACKOFF:   if (bo_cnt == bo_last) state_nxt = ISSUE;
      WAIT_DONE: if (tx_complete || timer_exp) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Pulses are suppressed while rst is high so an aborted transfer reports nothing
  always_comb begin
    tx_start     = 1'b0;
    done_pulse   = 1'b0;
    err_pulse    = 1'b0;
    err_code_nxt = err_code;
    if (!rst) begin
      case (state)
        ISSUE: tx_start = 1'b1;
        CHECK: begin
          if (bad_req) begin
            err_pulse    = 1'b1;
            err_code_nxt = 2'b01;
          end
        end
        WAIT_ACK: begin
          if (ack_fail && !retry_ok) begin
            err_pulse    = 1'b1;
            err_code_nxt = 2'b10;
          end
        end
        WAIT_DONE: begin
          if (tx_complete) begin
            done_pulse = 1'b1;
          end else if (timer_exp) begin
            err_pulse    = 1'b1;
            err_code_nxt = 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_dest   <= '0;
      tx_len    <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      bo_cnt    <= '0;
      err_code  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_dest   <= fifo_mem[rd_ptr].dest;
            tx_len    <= fifo_mem[rd_ptr].len;
            retry_cnt <= '0;
          end
        end
        ISSUE: timer <= '0;
        WAIT_ACK: begin
          if (ack_fail) begin
            if (retry_ok) retry_cnt <= retry_cnt + 1'b1;
            bo_cnt <= '0;
          end else if (tx_ack) begin
            timer <= '0;
          end else if (timer != 16'hFFFF) begin
            timer <= timer + 16'd1;
          end
        end
        BACKOFF:   if (bo_cnt != 16'hFFFF) bo_cnt <= bo_cnt + 16'd1;
        WAIT_DONE: if (timer != 16'hFFFF) timer <= timer + 16'd1;
        default: ;
      endcase
      if (err_pulse) err_code <= err_code_nxt;
    end
  end

`ifdef COMMS_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_count <= '0;
      fail_count <= '0;
    end else begin
      if (done_pulse && sent_count != 16'hFFFF) sent_count <= sent_count + 16'd1;
      if (err_pulse && fail_count != 16'hFFFF)  fail_count <= fail_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_comms_tx_scheduler.sv
// Directed bench for comms_tx_scheduler: reset, normal transfer, bad requests, NACK retry/backoff,
// completion timeout, FIFO full and ordering, reset mid-transfer.
module tb_comms_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] node_id, max_node;
  logic        req_valid;
  logic [15:0] req_dest, req_len;
  logic        req_ready;
  logic        tx_start;
  logic [15:0] tx_dest, tx_len;
  logic        tx_ack, tx_nack, tx_complete;
  logic        sched_busy, done_pulse, err_pulse;
  logic [1:0]  err_code;
`ifdef COMMS_SCHED_STATS_EN
  logic [15:0] sent_count, fail_count;
`endif

  always #5 clk = ~clk;

  comms_tx_scheduler dut (
    .clk(clk), .rst(rst), .node_id(node_id), .max_node(max_node),
    .req_valid(req_valid), .req_dest(req_dest), .req_len(req_len), .req_ready(req_ready),
    .tx_start(tx_start), .tx_dest(tx_dest), .tx_len(tx_len),
    .tx_ack(tx_ack), .tx_nack(tx_nack), .tx_complete(tx_complete),
    .sched_busy(sched_busy), .done_pulse(done_pulse), .err_pulse(err_pulse), .err_code(err_code)
`ifdef COMMS_SCHED_STATS_EN
    , .sent_count(sent_count), .fail_count(fail_count)
`endif
  );

  int cyc = 0, n_start = 0, n_done = 0, n_err = 0;
  int n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tx_start)   n_start <= n_start + 1;
    if (done_pulse) n_done  <= n_done + 1;
    if (err_pulse)  n_err   <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [15:0] l);
    drive_edge();
    req_valid = 1'b1;
    req_dest  = d;
    req_len   = l;
  endtask

  task automatic wait_start(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_start) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic serve(input string tag);
    drive_edge(); tx_ack = 1'b1;
    drive_edge(); tx_ack = 1'b0; tx_complete = 1'b1;
    @(negedge clk); chk(tag, done_pulse, 1);
    drive_edge(); tx_complete = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s [4];
    int a, e, base, be, bd;
    rst = 1'b1; req_valid = 1'b0; req_dest = '0; req_len = '0;
    tx_ack = 1'b0; tx_nack = 1'b0; tx_complete = 1'b0;
    node_id = 16'd2; max_node = 16'd4;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_tx_dest", tx_dest, 0);
    chk("rst_tx_len", tx_len, 0);

    // normal transfer: ack 3 cycles after start, complete 10 cycles after ack
    base = n_start;
    push(16'd1, 16'd8);
    drive_edge(); req_valid = 1'b0;
    @(negedge clk);
    chk("t1_busy_queued", sched_busy, 1);
    chk("t1_no_start_idle", tx_start, 0);
    @(negedge clk);
    chk("t1_dest", tx_dest, 1);
    chk("t1_len", tx_len, 8);
    chk("t1_no_start_check", tx_start, 0);
    @(negedge clk);
    chk("t1_start_latency", tx_start, 1);
    drive_edge(); tx_complete = 1'b1;
    @(negedge clk); chk("t1_stray_complete", done_pulse, 0);
    drive_edge(); tx_complete = 1'b0;
    drive_edge(); tx_ack = 1'b1;
    drive_edge(); tx_ack = 1'b0;
    repeat (8) drive_edge();
    drive_edge(); tx_complete = 1'b1;
    @(negedge clk);
    chk("t1_done", done_pulse, 1);
    chk("t1_no_err", err_pulse, 0);
    chk("t1_dest_held", tx_dest, 1);
    drive_edge(); tx_complete = 1'b0;
    @(negedge clk);
    chk("t1_idle_after", sched_busy, 0);
    chk("t1_one_start", n_start - base, 1);

    // invalid requests: own id, out of ring, zero length
    base = n_start; be = n_err;
    push(16'd2, 16'd4);
    push(16'd7, 16'd4);
    push(16'd1, 16'd0);
    drive_edge(); req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_err_count", n_err - be, 3);
    chk("t2_err_code", err_code, 1);
    chk("t2_no_start", n_start - base, 0);
    push(16'd3, 16'd5);
    drive_edge(); req_valid = 1'b0;
    wait_start(10, a);
    chk("t2_start_seen", a != -1, 1);
    chk("t2_dest", tx_dest, 3);
    serve("t2_done");

    // NACK every attempt; third attempt gets ack and nack together
    base = n_start; be = n_err;
    push(16'd3, 16'd2);
    drive_edge(); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_start(100, s[i]);
      chk("t3_start_seen", s[i] != -1, 1);
      drive_edge(); tx_nack = 1'b1; tx_ack = (i == 2);
      @(negedge clk); chk("t3_err_pulse", err_pulse, (i == 3));
      drive_edge(); tx_nack = 1'b0; tx_ack = 1'b0;
    end
    chk("t3_gap1", s[1] - s[0], 18);
    chk("t3_gap2", s[2] - s[1], 34);
    chk("t3_gap3", s[3] - s[2], 50);
    @(negedge clk);
    chk("t3_err_code", err_code, 2);
    chk("t3_starts", n_start - base, 4);
    chk("t3_errs", n_err - be, 1);

    // ack then no completion
    bd = n_done;
    push(16'd1, 16'd3);
    drive_edge(); req_valid = 1'b0;
    wait_start(10, a);
    chk("t4_start_seen", a != -1, 1);
    drive_edge(); tx_ack = 1'b1; a = cyc;
    drive_edge(); tx_ack = 1'b0;
    e = -1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (err_pulse) begin
        e = cyc;
        break;
      end
    end
    chk("t4_timeout_delay", e - a, 1024);
    @(negedge clk);
    chk("t4_err_code", err_code, 3);
    chk("t4_no_done", n_done - bd, 0);

    // fill FIFO behind an in-flight transfer, then service in order
    base = n_start; bd = n_done;
    push(16'd1, 16'd10);
    drive_edge(); req_valid = 1'b0;
    wait_start(10, a);
    chk("t5_start_seen0", a != -1, 1);
    for (int i = 0; i < 4; i++) push(16'd3, 16'(11 + i));
    drive_edge(); req_dest = 16'd3; req_len = 16'd15;
    @(negedge clk); chk("t5_full", req_ready, 0);
    drive_edge();
    @(negedge clk); chk("t5_still_full", req_ready, 0);
    drive_edge(); req_valid = 1'b0;
    chk("t5_len0", tx_len, 10);
    serve("t5_done0");
    for (int i = 0; i < 4; i++) begin
      wait_start(10, a);
      chk("t5_start_seen", a != -1, 1);
      chk("t5_len_order", tx_len, 32'(11 + i));
      serve("t5_done");
    end
    repeat (5) @(negedge clk);
    chk("t5_starts", n_start - base, 5);
    chk("t5_dones", n_done - bd, 5);
    chk("t5_idle", sched_busy, 0);

    // reset during WAIT_DONE with two queued
`ifdef COMMS_SCHED_STATS_EN
    chk("t6_sent_before", sent_count, 7);
    chk("t6_fail_before", fail_count, 5);
`endif
    base = n_start;
    push(16'd1, 16'd20);
    drive_edge(); req_valid = 1'b0;
    wait_start(10, a);
    chk("t6_start_seen", a != -1, 1);
    push(16'd3, 16'd21);
    push(16'd3, 16'd22);
    drive_edge(); req_valid = 1'b0; tx_ack = 1'b1;
    drive_edge(); tx_ack = 1'b0;
    @(negedge clk); chk("t6_busy_pre", sched_busy, 1);
    drive_edge(); rst = 1'b1; tx_complete = 1'b1;
    @(negedge clk);
    chk("t6_no_done_in_rst", done_pulse, 0);
    chk("t6_no_err_in_rst", err_pulse, 0);
    drive_edge(); rst = 1'b0; tx_complete = 1'b0;
    @(negedge clk);
    chk("t6_busy", sched_busy, 0);
    chk("t6_req_ready", req_ready, 1);
    chk("t6_tx_dest", tx_dest, 0);
    chk("t6_tx_len", tx_len, 0);
    chk("t6_err_code", err_code, 0);
    chk("t6_tx_start", tx_start, 0);
`ifdef COMMS_SCHED_STATS_EN
    chk("t6_sent_after", sent_count, 0);
    chk("t6_fail_after", fail_count, 0);
`endif
    repeat (20) @(negedge clk);
    chk("t6_no_more_start", n_start - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
